// File: rtl/domain_tdm_arbiter_if.sv
// ---------------------------------------------------------------------------
// domain_tdm_arbiter_if
//   Bundle of the request/grant and schedule signals between the two security
//   domains and the time-division arbiter in front of the shared resource.
//
//   Signals
//     req0/req1   domain request levels (driven by the requesters)
//     gnt0/gnt1   per-domain grants, at most one op per cycle
//     sel         current slot owner (0/1)
//     dead        high during the idle/drain phase after each slot
//     slot_left   cycles remaining in the current phase minus 1
//     gcnt0/gcnt1 saturating per-domain grant counters
//     scrub       resource clear strobe (constant 0 unless TDM_SCRUB_EN)
//
//   Modports
//     slave  : arbiter side (consumes requests, produces schedule/grants)
//     master : requester/resource side
// ---------------------------------------------------------------------------
interface domain_tdm_arbiter_if #(
  parameter int CNT_W = 4
) ();
  logic             req0;
  logic             req1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             dead;
  logic [CNT_W-1:0] slot_left;
  logic [7:0]       gcnt0;
  logic [7:0]       gcnt1;
  logic             scrub;

  modport slave (
    input  req0, req1,
    output gnt0, gnt1, sel, dead, slot_left, gcnt0, gcnt1, scrub
  );

  modport master (
    output req0, req1,
    input  gnt0, gnt1, sel, dead, slot_left, gcnt0, gcnt1, scrub
  );
endinterface

// File: rtl/domain_tdm_arbiter.sv
// ---------------------------------------------------------------------------
// domain_tdm_arbiter
//   Time-division arbiter sharing one resource between security domain 0 and
//   domain 1. The slot schedule is fixed and never looks at the requests, so
//   the schedule outputs leak nothing about either domain, and each domain's
//   grant/count outputs depend only on its own request plus the schedule.
//
//   Schedule: SLOT0 (SLOT_LEN) -> DEAD0 (DEAD_LEN) -> SLOT1 (SLOT_LEN)
//             -> DEAD1 (DEAD_LEN) -> SLOT0 ...   DEAD phases skipped when
//             DEAD_LEN == 0.
//
//   Parameters
//     SLOT_LEN  cycles per domain slot (>= 1)
//     DEAD_LEN  idle cycles after each slot (>= 0)
//     CNT_W     phase counter width, 2**CNT_W >= max(SLOT_LEN, DEAD_LEN)
//
//   Ports
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    domain_tdm_arbiter_if.slave (req0/1 in; gnt0/1, sel, dead,
//            slot_left, gcnt0/1, scrub out)
//
//   Build option
//     TDM_SCRUB_EN  when defined, scrub is high in every dead-phase cycle
//                   (or in the last cycle of each slot when DEAD_LEN == 0);
//                   when undefined, scrub is tied low.
//
//   All outputs are flops. Each one is loaded with the value it must show in
//   the coming cycle, computed from the next state and next pending bits, so
//   there is no combinational path from req* to any output.
// ---------------------------------------------------------------------------
module domain_tdm_arbiter #(
  parameter int SLOT_LEN = 4,
  parameter int DEAD_LEN = 1,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  domain_tdm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_SLOT0 = 2'd0,
    ST_DEAD0 = 2'd1,
    ST_SLOT1 = 2'd2,
    ST_DEAD1 = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_LEN > 0) ? (DEAD_LEN - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic             HAS_DEAD  = (DEAD_LEN > 0) ? 1'b1 : 1'b0;

  // Grant counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic en);
    logic [7:0] res;
    if (en && (val != 8'hFF)) begin
      res = val + 8'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] slot_left_q, slot_left_d;
  logic             pend0_q, pend0_d;
  logic             pend1_q, pend1_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sel_q, sel_d;
  logic             dead_q, dead_d;
  logic [7:0]       gcnt0_q, gcnt0_d;
  logic [7:0]       gcnt1_q, gcnt1_d;

  // Schedule sequencer: phase advance purely on the phase counter.
  always_comb begin
    state_d     = state_q;
    slot_left_d = slot_left_q;
    if (slot_left_q == CNT_ZERO) begin
      case (state_q)
        ST_SLOT0: begin
          if (HAS_DEAD) begin
            state_d     = ST_DEAD0;
            slot_left_d = DEAD_LAST;
          end else begin
            state_d     = ST_SLOT1;
            slot_left_d = SLOT_LAST;
          end
        end
        ST_DEAD0: begin
          state_d     = ST_SLOT1;
          slot_left_d = SLOT_LAST;
        end
        ST_SLOT1: begin
          if (HAS_DEAD) begin
            state_d     = ST_DEAD1;
            slot_left_d = DEAD_LAST;
          end else begin
            state_d     = ST_SLOT0;
            slot_left_d = SLOT_LAST;
          end
        end
        ST_DEAD1: begin
          state_d     = ST_SLOT0;
          slot_left_d = SLOT_LAST;
        end
        default: begin
          state_d     = ST_SLOT0;
          slot_left_d = SLOT_LAST;
        end
      endcase
    end else begin
      slot_left_d = slot_left_q - CNT_ONE;
    end
  end

  // Per-domain pending/grant/count paths; domain i only sees req_i and state.
  always_comb begin
    // A request arriving in the same cycle as a grant is a new request and
    // stays pending.
    pend0_d = bus.req0 | (pend0_q & ~gnt0_q);
    pend1_d = bus.req1 | (pend1_q & ~gnt1_q);
    gnt0_d  = (state_d == ST_SLOT0) & pend0_d;
    gnt1_d  = (state_d == ST_SLOT1) & pend1_d;
    gcnt0_d = sat_inc(gcnt0_q, gnt0_q);
    gcnt1_d = sat_inc(gcnt1_q, gnt1_q);
    sel_d   = (state_d == ST_SLOT1) || (state_d == ST_DEAD1);
    dead_d  = (state_d == ST_DEAD0) || (state_d == ST_DEAD1);
  end

  // State, pending and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SLOT0;
      slot_left_q <= SLOT_LAST;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b0;
      dead_q      <= 1'b0;
      gcnt0_q     <= 8'd0;
      gcnt1_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      slot_left_q <= slot_left_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      sel_q       <= sel_d;
      dead_q      <= dead_d;
      gcnt0_q     <= gcnt0_d;
      gcnt1_q     <= gcnt1_d;
    end
  end

`ifdef TDM_SCRUB_EN
  logic scrub_q, scrub_d;

  // Scrub strobe: follows dead, or marks the final slot cycle when there is
  // no dead phase to clear the resource in.
  always_comb begin
    scrub_d = 1'b0;
    if (HAS_DEAD) begin
      scrub_d = dead_d;
    end else begin
      scrub_d = ((state_d == ST_SLOT0) || (state_d == ST_SLOT1)) && (slot_left_d == CNT_ZERO);
    end
  end

  // Scrub register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scrub_q <= 1'b0;
    end else begin
      scrub_q <= scrub_d;
    end
  end

  assign bus.scrub = scrub_q;
`else
  assign bus.scrub = 1'b0;
`endif

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.sel       = sel_q;
  assign bus.dead      = dead_q;
  assign bus.slot_left = slot_left_q;
  assign bus.gcnt0     = gcnt0_q;
  assign bus.gcnt1     = gcnt1_q;

endmodule

// File: tb/tb_domain_tdm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_domain_tdm_arbiter
//   Self-checking bench for domain_tdm_arbiter. A reference model derives the
//   schedule from the cycle number since reset (position within the period)
//   and tracks pending/grant/count per domain from the request rules.
//   Compile with +define+TDM_SCRUB_EN to exercise the scrub build.
// ---------------------------------------------------------------------------
module tb_domain_tdm_arbiter;

  localparam int SLOT_LEN = 4;
  localparam int DEAD_LEN = 1;
  localparam int CNT_W    = 4;
  localparam int PER      = 2 * (SLOT_LEN + DEAD_LEN);

  logic clk;
  logic rst_n;

  domain_tdm_arbiter_if #(.CNT_W(CNT_W)) bus ();

  domain_tdm_arbiter #(
    .SLOT_LEN (SLOT_LEN),
    .DEAD_LEN (DEAD_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // model state
  int m_t;
  bit m_pend0, m_pend1;
  int m_gcnt0, m_gcnt1;

  bit req0_tab [0:59];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, m_t, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_t     = 0;
    m_pend0 = 1'b0;
    m_pend1 = 1'b0;
    m_gcnt0 = 0;
    m_gcnt1 = 0;
  endtask

  // Hold reset for a few cycles, check reset values, release just after an edge.
  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check_val("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check_val("rst_sel", 32'(bus.sel), 32'd0);
    check_val("rst_dead", 32'(bus.dead), 32'd0);
    check_val("rst_left", 32'(bus.slot_left), 32'(SLOT_LEN - 1));
    check_val("rst_gcnt0", 32'(bus.gcnt0), 32'd0);
    check_val("rst_gcnt1", 32'(bus.gcnt1), 32'd0);
    check_val("rst_scrub", 32'(bus.scrub), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: compare outputs for cycle m_t, drive requests, advance model.
  task automatic step(input bit r0, input bit r1);
    int  p;
    bit  in_slot0, in_slot1, e_sel, e_dead, e_gnt0, e_gnt1, e_scrub;
    int  e_left;
    @(negedge clk);
    p        = m_t % PER;
    in_slot0 = (p < SLOT_LEN);
    in_slot1 = (p >= SLOT_LEN + DEAD_LEN) && (p < 2 * SLOT_LEN + DEAD_LEN);
    e_sel    = (p >= SLOT_LEN + DEAD_LEN);
    e_dead   = !in_slot0 && !in_slot1;
    if (p < SLOT_LEN)                       e_left = SLOT_LEN - 1 - p;
    else if (p < SLOT_LEN + DEAD_LEN)       e_left = SLOT_LEN + DEAD_LEN - 1 - p;
    else if (p < 2 * SLOT_LEN + DEAD_LEN)   e_left = 2 * SLOT_LEN + DEAD_LEN - 1 - p;
    else                                    e_left = PER - 1 - p;
    e_gnt0 = in_slot0 && m_pend0;
    e_gnt1 = in_slot1 && m_pend1;
`ifdef TDM_SCRUB_EN
    if (DEAD_LEN > 0) e_scrub = e_dead;
    else              e_scrub = (in_slot0 || in_slot1) && (e_left == 0);
`else
    e_scrub = 1'b0;
`endif
    check_val("sel", 32'(bus.sel), 32'(e_sel));
    check_val("dead", 32'(bus.dead), 32'(e_dead));
    check_val("slot_left", 32'(bus.slot_left), 32'(e_left));
    check_val("gnt0", 32'(bus.gnt0), 32'(e_gnt0));
    check_val("gnt1", 32'(bus.gnt1), 32'(e_gnt1));
    check_val("gcnt0", 32'(bus.gcnt0), 32'(m_gcnt0));
    check_val("gcnt1", 32'(bus.gcnt1), 32'(m_gcnt1));
    check_val("scrub", 32'(bus.scrub), 32'(e_scrub));
    bus.req0 = r0;
    bus.req1 = r1;
    @(posedge clk);
    if (e_gnt0 && m_gcnt0 < 255) m_gcnt0++;
    if (e_gnt1 && m_gcnt1 < 255) m_gcnt1++;
    m_pend0 = r0 | (m_pend0 & !e_gnt0);
    m_pend1 = r1 | (m_pend1 & !e_gnt1);
    m_t++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();

    // Idle schedule, no requests.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // req0 held from cycle 0: 11 grants by cycle 30.
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    #1;
    check_val("t2_gcnt0_at30", 32'(bus.gcnt0), 32'd11);
    check_val("t2_gcnt1_at30", 32'(bus.gcnt1), 32'd0);

    // Single req1 pulse at cycle 2: one grant in the first SLOT1 cycle.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, (i == 2));
    #1;
    check_val("t3_gcnt1", 32'(bus.gcnt1), 32'd1);

    // Fully random traffic on both domains.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Same req0 sequence twice against different random req1 streams.
    for (int i = 0; i < 60; i++) req0_tab[i] = 1'($urandom_range(0, 1));
    for (int run = 0; run < 2; run++) begin
      do_reset();
      for (int i = 0; i < 60; i++) step(req0_tab[i], 1'($urandom_range(0, 1)));
    end

    // Async reset in SLOT1 with domain 0 pending; pending must be dropped.
    do_reset();
    for (int i = 0; i < 7; i++) step((i == 5), 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t5_gnt0", 32'(bus.gnt0), 32'd0);
    check_val("t5_gnt1", 32'(bus.gnt1), 32'd0);
    check_val("t5_sel", 32'(bus.sel), 32'd0);
    check_val("t5_dead", 32'(bus.dead), 32'd0);
    check_val("t5_gcnt0", 32'(bus.gcnt0), 32'd0);
    check_val("t5_scrub", 32'(bus.scrub), 32'd0);
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);

    // Long req0 run: counter saturates at 255.
    do_reset();
    for (int i = 0; i < 700; i++) step(1'b1, 1'($urandom_range(0, 1)));
    #1;
    check_val("t6_gcnt0_sat", 32'(bus.gcnt0), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
